// File: rtl/hall_decoder.sv
// Hall-sensor front end: synchronizes, debounces and decodes three hall inputs into a rotor
// sector, direction, fault/sequence flags and a sector-to-sector period measurement.
module hall_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PERIOD_W        = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          hall,
    output logic [2:0]          sector,
    output logic                sector_valid,
    output logic                dir,
    output logic                edge_pulse,
    output logic                hall_fault,
    output logic                seq_err,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stall
);

    localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCNT_W-1:0]   DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;

    logic [2:0]          s1_q, s2_q, cand_q, acc_q;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [2:0]          sector_q, sector_d;
    logic                valid_q, valid_d;
    logic                dir_q, dir_d;
    logic                edge_q, edge_d;
    logic                fault_q, fault_d;
    logic                seq_q, seq_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pvalid_q, pvalid_d;
    logic                stall_q, stall_d;
    logic                have_ref_q, have_ref_d;

    logic       accept;
    logic       acquire;
    logic       new_legal;
    logic [2:0] new_sector;
    logic [2:0] sector_next, sector_prev;

    // Returns {legal, sector}; 000 and 111 are illegal.
    function automatic logic [3:0] decode(input logic [2:0] code);
        case (code)
            3'b101:  decode = {1'b1, 3'd0};
            3'b100:  decode = {1'b1, 3'd1};
            3'b110:  decode = {1'b1, 3'd2};
            3'b010:  decode = {1'b1, 3'd3};
            3'b011:  decode = {1'b1, 3'd4};
            3'b001:  decode = {1'b1, 3'd5};
            default: decode = {1'b0, 3'd0};
        endcase
    endfunction

    assign accept                  = (dcnt_q == DCNT_MAX) && (cand_q != acc_q);
    assign {new_legal, new_sector} = decode(cand_q);
    assign sector_next             = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
    assign sector_prev             = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;

    always_comb begin
        dcnt_d = dcnt_q;
        if (s2_q != cand_q) begin
            dcnt_d = '0;
        end else if (dcnt_q != DCNT_MAX) begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_comb begin
        sector_d = sector_q;
        valid_d  = valid_q;
        dir_d    = dir_q;
        edge_d   = 1'b0;
        fault_d  = fault_q;
        seq_d    = 1'b0;
        acquire  = 1'b0;
        if (accept) begin
            if (!new_legal) begin
                fault_d = 1'b1;
            end else begin
                fault_d = 1'b0;
                if (!valid_q) begin
                    sector_d = new_sector;
                    valid_d  = 1'b1;
                    acquire  = 1'b1;
                end else if (new_sector != sector_q) begin
                    // Equal sector here means a return from an illegal code: no event.
                    sector_d = new_sector;
                    edge_d   = 1'b1;
                    if (new_sector == sector_next) begin
                        dir_d = 1'b1;
                    end else if (new_sector == sector_prev) begin
                        dir_d = 1'b0;
                    end else begin
                        seq_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        pcnt_d     = pcnt_q;
        period_d   = period_q;
        pvalid_d   = pvalid_q;
        stall_d    = stall_q;
        have_ref_d = have_ref_q;
        if (edge_q || acquire) begin
            pcnt_d = '0;
        end else if (pcnt_q != PCNT_MAX) begin
            pcnt_d = pcnt_q + 1'b1;
        end
        if (edge_q) begin
            // pcnt counts from 0 in the cycle after the previous pulse, hence the +1.
            if (have_ref_q && !stall_q && (pcnt_q != PCNT_MAX)) begin
                period_d = pcnt_q + 1'b1;
                pvalid_d = 1'b1;
            end else begin
                have_ref_d = 1'b1;
                stall_d    = 1'b0;
                pvalid_d   = 1'b0;
            end
        end else if (pcnt_q == PCNT_MAX) begin
            stall_d  = 1'b1;
            pvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            cand_q     <= '0;
            acc_q      <= '0;
            dcnt_q     <= '0;
            sector_q   <= '0;
            valid_q    <= 1'b0;
            dir_q      <= 1'b1;
            edge_q     <= 1'b0;
            fault_q    <= 1'b0;
            seq_q      <= 1'b0;
            pcnt_q     <= '0;
            period_q   <= '0;
            pvalid_q   <= 1'b0;
            stall_q    <= 1'b0;
            have_ref_q <= 1'b0;
        end else begin
            s1_q       <= hall;
            s2_q       <= s1_q;
            cand_q     <= s2_q;
            dcnt_q     <= dcnt_d;
            if (accept) begin
                acc_q <= cand_q;
            end
            sector_q   <= sector_d;
            valid_q    <= valid_d;
            dir_q      <= dir_d;
            edge_q     <= edge_d;
            fault_q    <= fault_d;
            seq_q      <= seq_d;
            pcnt_q     <= pcnt_d;
            period_q   <= period_d;
            pvalid_q   <= pvalid_d;
            stall_q    <= stall_d;
            have_ref_q <= have_ref_d;
        end
    end

    assign sector       = sector_q;
    assign sector_valid = valid_q;
    assign dir          = dir_q;
    assign edge_pulse   = edge_q;
    assign hall_fault   = fault_q;
    assign seq_err      = seq_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign stall        = stall_q;

endmodule

// File: tb/tb_hall_decoder.sv
// Directed bench for hall_decoder with DEBOUNCE_CYCLES=4, PERIOD_W=8.
module tb_hall_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] hall;
    logic [2:0] sector;
    logic       sector_valid, dir, edge_pulse, hall_fault, seq_err;
    logic [7:0] period;
    logic       period_valid, stall;

    int checks   = 0;
    int failures = 0;
    int ep_cnt;
    int se_cnt;

    always #5 clk = ~clk;

    hall_decoder #(
        .DEBOUNCE_CYCLES(4),
        .PERIOD_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hall        (hall),
        .sector      (sector),
        .sector_valid(sector_valid),
        .dir         (dir),
        .edge_pulse  (edge_pulse),
        .hall_fault  (hall_fault),
        .seq_err     (seq_err),
        .period      (period),
        .period_valid(period_valid),
        .stall       (stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_sector"}, 32'(sector), 0);
        check_eq({tag, "_valid"}, 32'(sector_valid), 0);
        check_eq({tag, "_dir"}, 32'(dir), 1);
        check_eq({tag, "_edge"}, 32'(edge_pulse), 0);
        check_eq({tag, "_fault"}, 32'(hall_fault), 0);
        check_eq({tag, "_seqerr"}, 32'(seq_err), 0);
        check_eq({tag, "_period"}, 32'(period), 0);
        check_eq({tag, "_pvalid"}, 32'(period_valid), 0);
        check_eq({tag, "_stall"}, 32'(stall), 0);
    endtask

    // Drive a code for a number of cycles, counting pulses seen at each negedge.
    task automatic hold(input logic [2:0] code, input int cycles);
        hall   = code;
        ep_cnt = 0;
        se_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            ep_cnt += int'(edge_pulse);
            se_cnt += int'(seq_err);
        end
    endtask

    logic [2:0] fwd_code [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    logic [2:0] fwd_sec  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

    initial begin
        rst  = 1'b1;
        hall = 3'b101;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;

        // First acquisition lands on edge 7 after release.
        repeat (6) @(negedge clk);
        check_eq("acq_pre_valid", 32'(sector_valid), 0);
        @(negedge clk);
        check_eq("acq_sector", 32'(sector), 0);
        check_eq("acq_valid", 32'(sector_valid), 1);
        check_eq("acq_edge", 32'(edge_pulse), 0);
        check_eq("acq_pvalid", 32'(period_valid), 0);
        check_eq("acq_fault", 32'(hall_fault), 0);
        hold(3'b101, 13);

        for (int i = 0; i < 6; i++) begin
            hold(fwd_code[i], 20);
            check_eq($sformatf("fwd%0d_sector", i), 32'(sector), 32'(fwd_sec[i]));
            check_eq($sformatf("fwd%0d_edges", i), ep_cnt, 1);
            check_eq($sformatf("fwd%0d_dir", i), 32'(dir), 1);
            check_eq($sformatf("fwd%0d_seqerr", i), se_cnt, 0);
            if (i == 0) begin
                check_eq("fwd0_pvalid", 32'(period_valid), 0);
            end else begin
                check_eq($sformatf("fwd%0d_period", i), 32'(period), 20);
                check_eq($sformatf("fwd%0d_pvalid", i), 32'(period_valid), 1);
            end
        end

        // Advance to sector 3, then reverse.
        hold(3'b100, 20);
        hold(3'b110, 20);
        hold(3'b010, 20);
        check_eq("to3_sector", 32'(sector), 3);
        hold(3'b110, 20);
        check_eq("rev1_sector", 32'(sector), 2);
        check_eq("rev1_dir", 32'(dir), 0);
        check_eq("rev1_edges", ep_cnt, 1);
        hold(3'b100, 20);
        check_eq("rev2_sector", 32'(sector), 1);
        check_eq("rev2_dir", 32'(dir), 0);
        check_eq("rev2_period", 32'(period), 20);
        hold(3'b101, 20);
        check_eq("rev3_sector", 32'(sector), 0);

        // 3-cycle glitch must be rejected.
        hold(3'b100, 3);
        check_eq("glitch_edges_a", ep_cnt, 0);
        hold(3'b101, 20);
        check_eq("glitch_edges_b", ep_cnt, 0);
        check_eq("glitch_sector", 32'(sector), 0);

        // Skip 0 -> 3.
        hold(3'b010, 20);
        check_eq("skip_sector", 32'(sector), 3);
        check_eq("skip_seqerr", se_cnt, 1);
        check_eq("skip_edges", ep_cnt, 1);
        check_eq("skip_dir", 32'(dir), 0);

        // Illegal code, then return to same sector.
        hold(3'b111, 20);
        check_eq("ill_fault", 32'(hall_fault), 1);
        check_eq("ill_sector", 32'(sector), 3);
        check_eq("ill_valid", 32'(sector_valid), 1);
        check_eq("ill_edges", ep_cnt, 0);
        hold(3'b010, 20);
        check_eq("ret_fault", 32'(hall_fault), 0);
        check_eq("ret_sector", 32'(sector), 3);
        check_eq("ret_edges", ep_cnt, 0);
        check_eq("ret_seqerr", se_cnt, 0);

        // Edge at 011 is 60 cycles after the skip edge, then a long hold stalls.
        hold(3'b011, 300);
        check_eq("stall_sector", 32'(sector), 4);
        check_eq("stall_dir", 32'(dir), 1);
        check_eq("stall_flag", 32'(stall), 1);
        check_eq("stall_pvalid", 32'(period_valid), 0);
        check_eq("stall_period_held", 32'(period), 60);
        hold(3'b001, 20);
        check_eq("unstall_sector", 32'(sector), 5);
        check_eq("unstall_flag", 32'(stall), 0);
        check_eq("unstall_pvalid", 32'(period_valid), 0);
        check_eq("unstall_edges", ep_cnt, 1);
        hold(3'b101, 20);
        check_eq("remeas_sector", 32'(sector), 0);
        check_eq("remeas_pvalid", 32'(period_valid), 1);
        check_eq("remeas_period", 32'(period), 20);

        // Asynchronous reset while an edge pulse is high.
        hold(3'b100, 7);
        check_eq("pre_rst_edge", 32'(edge_pulse), 1);
        check_eq("pre_rst_sector", 32'(sector), 1);
        rst = 1'b1;
        #1;
        check_reset("rst1");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("reacq_pre_valid", 32'(sector_valid), 0);
        @(negedge clk);
        check_eq("reacq_valid", 32'(sector_valid), 1);
        check_eq("reacq_sector", 32'(sector), 1);
        check_eq("reacq_edge", 32'(edge_pulse), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
